// File: rtl/line_clear_engine_if.sv
// Board handshake between the game FSM (master) and the line-clear engine (slave).
// LINE_CLEAR_SCORE_EN adds the score and total_lines result fields.
interface line_clear_engine_if #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
);
  logic                            start;
  logic [BOARD_W-1:0][BOARD_H-1:0] in_state;
  logic                            busy;
  logic                            done;
  logic [BOARD_W-1:0][BOARD_H-1:0] out_state;
  logic [4:0]                      lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
  logic [23:0]                     score;
  logic [15:0]                     total_lines;

  modport master (
    output start, in_state,
    input  busy, done, out_state, lines_cleared, score, total_lines
  );
  modport slave (
    input  start, in_state,
    output busy, done, out_state, lines_cleared, score, total_lines
  );
`else
  modport master (
    output start, in_state,
    input  busy, done, out_state, lines_cleared
  );
  modport slave (
    input  start, in_state,
    output busy, done, out_state, lines_cleared
  );
`endif
endinterface

// File: rtl/line_clear_engine.sv
// Finds full rows in a locked board and collapses them one per cycle toward the bottom row.
// Optional scoring (score / total_lines) is enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input logic               clk,
  input logic               reset,
  line_clear_engine_if.slave bus
);

  localparam int ROW_W = $clog2(BOARD_H);

  typedef logic [BOARD_W-1:0][BOARD_H-1:0] board_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  board_t           work_p0;
  logic [ROW_W-1:0] row_p0;
  logic [4:0]       cnt_p0;
  logic             row_full;
  board_t           shifted;

`ifdef LINE_CLEAR_SCORE_EN
  function automatic logic [23:0] score_inc(input logic [4:0] lines);
    case (lines)
      5'd0:    score_inc = 24'd0;
      5'd1:    score_inc = 24'd40;
      5'd2:    score_inc = 24'd100;
      5'd3:    score_inc = 24'd300;
      default: score_inc = 24'd1200;
    endcase
  endfunction

  function automatic logic [23:0] sat_add24(input logic [23:0] a, input logic [23:0] b);
    logic [24:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add24 = sum[24] ? 24'hFF_FFFF : sum[23:0];
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {12'd0, b};
    sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction
`endif

  // Row evaluation: fullness of row r and the board with row r removed
  always_comb begin
    row_full = 1'b1;
    for (int x = 0; x < BOARD_W; x++) begin
      row_full = row_full & work_p0[x][row_p0];
    end
  end

  always_comb begin
    shifted = work_p0;
    for (int x = 0; x < BOARD_W; x++) begin
      shifted[x][0] = 1'b0;
      for (int y = 1; y < BOARD_H; y++) begin
        if (ROW_W'(y) <= row_p0) begin
          shifted[x][y] = work_p0[x][y-1];
        end
      end
    end
  end

  // Working board is pure data: loaded on accept, rewritten on each clear
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      work_p0 <= bus.in_state;
    end else if (state == SCAN && row_full) begin
      work_p0 <= shifted;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      row_p0            <= ROW_W'(BOARD_H - 1);
      cnt_p0            <= 5'd0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.out_state     <= '0;
      bus.lines_cleared <= 5'd0;
`ifdef LINE_CLEAR_SCORE_EN
      bus.score         <= 24'd0;
      bus.total_lines   <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state    <= SCAN;
            bus.busy <= 1'b1;
            row_p0   <= ROW_W'(BOARD_H - 1);
            cnt_p0   <= 5'd0;
          end
        end
        SCAN: begin
          if (row_full) begin
            cnt_p0 <= cnt_p0 + 5'd1;
          end else if (row_p0 != '0) begin
            row_p0 <= row_p0 - ROW_W'(1);
          end else begin
            state             <= DONE;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b1;
            bus.out_state     <= work_p0;
            bus.lines_cleared <= cnt_p0;
`ifdef LINE_CLEAR_SCORE_EN
            bus.score         <= sat_add24(bus.score, score_inc(cnt_p0));
            bus.total_lines   <= sat_add16(bus.total_lines, cnt_p0);
`endif
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Sits directly downstream of the active-piece overlay stage.
- When a piece locks, the game FSM pulses start with the merged board (locked board plus the overlaid piece).
- The block finds full rows, collapses them one per cycle with gravity toward row 19, and returns the new locked board and a count of cleared lines.
- Its output board becomes the base board for subsequent overlays.

Parameters:
- BOARD_W, 10, number of columns (x); must match game_state_pkg screen outer dimension.
- BOARD_H, 20, number of rows (y); must match screen inner dimension. y=0 is the top row; y=BOARD_H-1 is the bottom row.

Ports:
- clk, input, 1, game clock.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, one-cycle request to process in_state.
- in_state, input, game_state_t, merged board; sampled only on an accepted start.
- busy, output, 1, high while the scan is in progress.
- done, output, 1, one-cycle pulse when out_state and lines_cleared are valid.
- out_state, output, game_state_t, collapsed board; holds until the next accepted start.
- lines_cleared, output, 5, number of rows removed in the last run (0..20).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port named reset.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, lines_cleared = 0.
  - out_state = all zeros.
  - Internal row pointer = BOARD_H-1.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1: capture in_state into the working board, set count = 0 and r = BOARD_H-1, go to SCAN.
  - start=0: stay in IDLE.
- SCAN (busy=1) evaluates row r once per cycle.
  - Row full: screen[x][r] = 1 for every x in 0..BOARD_W-1.
  - Row full:
    - For each y ≤ r, row y takes row y-1; row 0 is zero-filled. Rows below r are unchanged.
    - count++, r unchanged (the row shifted in is re-checked next cycle).
  - Row not full, r > 0: r--.
  - Row not full, r = 0: write the working board to out_state and count to lines_cleared, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: SCAN lasts BOARD_H + k cycles, where k is the number of full rows. done is high in cycle BOARD_H + k + 1 after the start-sampling edge. Examples: 21 cycles with no clears, 41 cycles for a fully-filled board.
- Full board: after all rows clear, row 0 is an all-zero row and is not full, so the scan terminates. Maximum k = 20.
- start while in SCAN or DONE: ignored, with no queueing. The upstream FSM must wait for done.
- in_state changes after the accepted start have no effect.
- out_state and lines_cleared update only on entry to DONE. Both are stable during SCAN and reflect the previous run.
- reset mid-SCAN: immediate return to IDLE. The partial result is discarded and outputs go to their reset values.
- Column ordering and bit positions are preserved exactly; only row index changes.

Optional Feature:
- Macro: LINE_CLEAR_SCORE_EN.
- Defined: adds outputs score (24 bits) and total_lines (16 bits). Both are reset to 0.
  - On entry to DONE, total_lines += count, saturating at 0xFFFF.
  - On entry to DONE, score += table[count]: 0, 40, 100, 300, 1200 for count 0..4. count > 4 adds 1200. Score saturates at 0xFFFFFF.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Empty board, start -> done in cycle 21, lines_cleared=0, out_state all zeros, busy high cycles 1-20.
- Row 19 full, screen[3][18]=1 only -> done in cycle 22, lines_cleared=1, out_state has only screen[3][19]=1.
- Rows 16-19 full, screen[0][15]=1 -> done in cycle 25, lines_cleared=4, only screen[0][19]=1. With LINE_CLEAR_SCORE_EN: score=1200, total_lines=4.
- Rows 17 and 19 full, row 18 = columns 0-8, screen[9][16]=1 -> lines_cleared=2. Result row 19 = columns 0-8, screen[9][18]=1, all else 0.
- All 200 cells set -> done in cycle 41, lines_cleared=20, out_state all zeros.
- Start a run, then:
  - Pulse start again in cycle 5 -> ignored; the first result is unchanged.
  - Assert reset in cycle 8 -> busy=0 immediately and no done pulse.
  - Start afterwards -> normal completion.
